tile_scheduler: RTL and testbench

Layer-level scheduler that sequences one full convolution layer as a series of systolic tiles. Each tile is one output-row segment of SYSTOLIC_SIZE pixels times one group of SYSTOLIC_SIZE filters. For each tile the block issues a start pulse to main_controller, waits for its done, and publishes registered base addresses for the ifm, wgt and ofm address controllers. It sits in TOP above main_controller and the three address controllers.

---
 rtl/tile_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_tile_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// ---------------------------------------------------------------------------
// tile_scheduler
//
// Sequences one convolution layer as a series of systolic tiles. A tile is
// one output-row segment of SYSTOLIC_SIZE pixels times one group of
// SYSTOLIC_SIZE filters. Loop order, outermost first: filter_grp, tile_row,
// col_seg. For each tile the block pulses tile_start, waits for tile_done,
// and holds registered base addresses for the ifm/wgt/ofm address
// controllers. Bases are kept as running sums, so no multipliers are needed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   layer_start  one-cycle request to run a layer (ignored while busy)
//   abort        synchronous abort; returns to idle with cleared state
//   tile_done    done pulse from main_controller (honoured only in WAIT)
//   tile_start   one-cycle start pulse to main_controller
//   ifm_base     ifm element offset of the current tile
//   wgt_base     wgt line offset of the current tile
//   ofm_base     ofm element offset of the current tile
//   filter_grp   current filter-group index
//   tile_row     current output-row index
//   col_seg      current column-segment index
//   busy         high while a layer is in progress
//   layer_done   one-cycle pulse after the last tile completes
// ---------------------------------------------------------------------------
module tile_scheduler #(
    parameter int SYSTOLIC_SIZE  = 16,
    parameter int OFM_SIZE       = 32,
    parameter int IFM_SIZE       = 34,
    parameter int IFM_CHANNEL    = 3,
    parameter int KERNEL_SIZE    = 3,
    parameter int NO_FILTER      = 32,
    parameter int IFM_ADDR_WIDTH = 19,
    parameter int WGT_ADDR_WIDTH = 9,
    parameter int OFM_ADDR_WIDTH = 22,
    localparam int NCS  = OFM_SIZE / SYSTOLIC_SIZE,
    localparam int NFG  = NO_FILTER / SYSTOLIC_SIZE,
    localparam int FG_W = (NFG > 1) ? $clog2(NFG) : 1,
    localparam int TR_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1,
    localparam int CS_W = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      layer_start,
    input  logic                      abort,
    input  logic                      tile_done,
    output logic                      tile_start,
    output logic [IFM_ADDR_WIDTH-1:0] ifm_base,
    output logic [WGT_ADDR_WIDTH-1:0] wgt_base,
    output logic [OFM_ADDR_WIDTH-1:0] ofm_base,
    output logic [FG_W-1:0]           filter_grp,
    output logic [TR_W-1:0]           tile_row,
    output logic [CS_W-1:0]           col_seg,
    output logic                      busy,
    output logic                      layer_done
);

    // Address increments for each loop level, pre-truncated to port width.
    localparam logic [IFM_ADDR_WIDTH-1:0] IFM_SEG_STEP = IFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [IFM_ADDR_WIDTH-1:0] IFM_ROW_STEP = IFM_ADDR_WIDTH'(IFM_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] OFM_SEG_STEP = OFM_ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] OFM_ROW_STEP = OFM_ADDR_WIDTH'(OFM_SIZE);
    localparam logic [OFM_ADDR_WIDTH-1:0] OFM_GRP_STEP =
        OFM_ADDR_WIDTH'(SYSTOLIC_SIZE * OFM_SIZE * OFM_SIZE);
    localparam logic [WGT_ADDR_WIDTH-1:0] WGT_GRP_STEP =
        WGT_ADDR_WIDTH'(KERNEL_SIZE * KERNEL_SIZE * IFM_CHANNEL);

    localparam logic [FG_W-1:0] FG_LAST = FG_W'(NFG - 1);
    localparam logic [TR_W-1:0] TR_LAST = TR_W'(OFM_SIZE - 1);
    localparam logic [CS_W-1:0] CS_LAST = CS_W'(NCS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t state_reg;

    // Running sums at the start of the current row:
    //   ifm_row_reg = tile_row*IFM_SIZE
    //   ofm_grp_reg = filter_grp*SYSTOLIC_SIZE*OFM_SIZE^2
    //   ofm_row_reg = ofm_grp_reg + tile_row*OFM_SIZE
    logic [IFM_ADDR_WIDTH-1:0] ifm_row_reg;
    logic [OFM_ADDR_WIDTH-1:0] ofm_grp_reg;
    logic [OFM_ADDR_WIDTH-1:0] ofm_row_reg;

    logic kill;        // reset or abort of an active layer
    logic accept;      // layer_start honoured this cycle
    logic clear_all;   // zero all counters and bases
    logic last_tile;
    logic step_tile;   // move to the next tile

    assign kill      = !rst_n || (abort && (state_reg != S_IDLE));
    assign accept    = (state_reg == S_IDLE) && layer_start && !abort;
    assign clear_all = kill || accept;
    assign last_tile = (filter_grp == FG_LAST) && (tile_row == TR_LAST) && (col_seg == CS_LAST);
    assign step_tile = (state_reg == S_ADVANCE) && !last_tile;

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (kill) begin
            state_reg  <= S_IDLE;
            tile_start <= 1'b0;
            layer_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tile_start <= 1'b0;
            layer_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg  <= S_ISSUE;
                        tile_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ISSUE: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (tile_done) begin
                        state_reg <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (last_tile) begin
                        state_reg  <= S_FINISH;
                        layer_done <= 1'b1;
                    end else begin
                        state_reg  <= S_ISSUE;
                        tile_start <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Loop counters and base-address accumulators. The carry chain runs
    // col_seg -> tile_row -> filter_grp; each level reloads the bases from
    // the running sum of the level above it.
    always_ff @(posedge clk) begin
        if (clear_all) begin
            filter_grp  <= '0;
            tile_row    <= '0;
            col_seg     <= '0;
            ifm_base    <= '0;
            wgt_base    <= '0;
            ofm_base    <= '0;
            ifm_row_reg <= '0;
            ofm_grp_reg <= '0;
            ofm_row_reg <= '0;
        end else if (step_tile) begin
            if (col_seg != CS_LAST) begin
                col_seg  <= col_seg + CS_W'(1);
                ifm_base <= ifm_base + IFM_SEG_STEP;
                ofm_base <= ofm_base + OFM_SEG_STEP;
            end else if (tile_row != TR_LAST) begin
                col_seg     <= '0;
                tile_row    <= tile_row + TR_W'(1);
                ifm_row_reg <= ifm_row_reg + IFM_ROW_STEP;
                ifm_base    <= ifm_row_reg + IFM_ROW_STEP;
                ofm_row_reg <= ofm_row_reg + OFM_ROW_STEP;
                ofm_base    <= ofm_row_reg + OFM_ROW_STEP;
            end else begin
                col_seg     <= '0;
                tile_row    <= '0;
                filter_grp  <= filter_grp + FG_W'(1);
                wgt_base    <= wgt_base + WGT_GRP_STEP;
                ifm_row_reg <= '0;
                ifm_base    <= '0;
                ofm_grp_reg <= ofm_grp_reg + OFM_GRP_STEP;
                ofm_row_reg <= ofm_grp_reg + OFM_GRP_STEP;
                ofm_base    <= ofm_grp_reg + OFM_GRP_STEP;
            end
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

    localparam int S     = 16;
    localparam int O     = 32;
    localparam int IFMS  = 34;
    localparam int C     = 3;
    localparam int K     = 3;
    localparam int NCS   = 2;
    localparam int TOTAL = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        layer_start;
    logic        abort;
    logic        tile_done;
    logic        tile_start;
    logic [18:0] ifm_base;
    logic [8:0]  wgt_base;
    logic [21:0] ofm_base;
    logic [0:0]  filter_grp;
    logic [4:0]  tile_row;
    logic [0:0]  col_seg;
    logic        busy;
    logic        layer_done;

    tile_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .layer_start(layer_start),
        .abort      (abort),
        .tile_done  (tile_done),
        .tile_start (tile_start),
        .ifm_base   (ifm_base),
        .wgt_base   (wgt_base),
        .ofm_base   (ofm_base),
        .filter_grp (filter_grp),
        .tile_row   (tile_row),
        .col_seg    (col_seg),
        .busy       (busy),
        .layer_done (layer_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Responder controls
    bit dly_rand = 0;
    bit abuse    = 0;
    bit spurious = 0;
    int n_starts = 0;

    // ------------------------------------------------------------------
    // Timeline reference model: tracks which cycle numbers must carry a
    // tile_start or layer_done, which tile index is current, and whether
    // the block is active. Expectations are for the cycle after each edge.
    // ------------------------------------------------------------------
    bit m_started = 0;
    bit m_active  = 0;
    bit m_cleared = 0;
    int m_t = 0;
    int m_issue_cyc = -10;
    int m_evt_cyc = -1;
    int m_done_cyc = -1;
    bit exp_start, exp_busy, exp_done, exp_idx, exp_zero;

    initial begin : model
        bit was;
        int n;
        forever begin
            @(posedge clk);
            was = m_active;
            n = cyc + 1;
            if (!rst_n || (abort && was)) begin
                m_active = 0; m_cleared = 1; m_started = 1;
                m_evt_cyc = -1; m_done_cyc = -1; m_issue_cyc = -10;
            end else if (!was) begin
                if (layer_start && !abort) begin
                    m_active = 1; m_t = 0; m_issue_cyc = n;
                    m_evt_cyc = -1; m_done_cyc = -1;
                end
            end else if (cyc == m_done_cyc) begin
                m_active = 0; m_cleared = 0;
            end else begin
                if (cyc > m_issue_cyc && m_evt_cyc < 0 && m_done_cyc < 0 && tile_done) begin
                    if (m_t == TOTAL - 1) m_done_cyc = cyc + 2;
                    else                  m_evt_cyc  = cyc + 2;
                end
                if (n == m_evt_cyc) begin
                    m_t++; m_issue_cyc = n; m_evt_cyc = -1;
                end
            end
            exp_start = m_active && (n == m_issue_cyc);
            exp_done  = m_active && (n == m_done_cyc);
            exp_busy  = m_active;
            exp_idx   = m_active && m_evt_cyc < 0 && m_done_cyc < 0;
            exp_zero  = !m_active && m_cleared;
            cyc = n;
        end
    end

    // Compare process
    initial begin : compare
        int g, r, sg;
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("tile_start", tile_start, exp_start);
                chk("busy", busy, exp_busy);
                chk("layer_done", layer_done, exp_done);
                if (exp_idx) begin
                    g  = m_t / (O * NCS);
                    r  = (m_t / NCS) % O;
                    sg = m_t % NCS;
                    chk("filter_grp", filter_grp, g);
                    chk("tile_row", tile_row, r);
                    chk("col_seg", col_seg, sg);
                    chk("ifm_base", ifm_base, r * IFMS + sg * S);
                    chk("wgt_base", wgt_base, g * K * K * C);
                    chk("ofm_base", ofm_base, g * S * O * O + r * O + sg * S);
                    if (exp_start) begin
                        case (m_t)
                            0: begin
                                chk("pin0_ifm", ifm_base, 0);
                                chk("pin0_wgt", wgt_base, 0);
                                chk("pin0_ofm", ofm_base, 0);
                            end
                            1: begin
                                chk("pin1_seg", col_seg, 1);
                                chk("pin1_ifm", ifm_base, 16);
                                chk("pin1_ofm", ofm_base, 16);
                            end
                            2: begin
                                chk("pin2_row", tile_row, 1);
                                chk("pin2_ifm", ifm_base, 34);
                                chk("pin2_ofm", ofm_base, 32);
                            end
                            64: begin
                                chk("pin64_grp", filter_grp, 1);
                                chk("pin64_wgt", wgt_base, 27);
                                chk("pin64_ofm", ofm_base, 16384);
                                chk("pin64_ifm", ifm_base, 0);
                            end
                            127: begin
                                chk("pin127_ifm", ifm_base, 1070);
                                chk("pin127_ofm", ofm_base, 17392);
                            end
                            default: ;
                        endcase
                    end
                end
                if (exp_zero) begin
                    chk("idle_ifm", ifm_base, 0);
                    chk("idle_wgt", wgt_base, 0);
                    chk("idle_ofm", ofm_base, 0);
                    chk("idle_grp", filter_grp, 0);
                    chk("idle_row", tile_row, 0);
                    chk("idle_seg", col_seg, 0);
                end
            end
        end
    end

    // tile_done responder
    initial begin : responder
        int cnt;
        cnt = 0;
        tile_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tile_done = 1'b0;
            if (tile_start) begin
                n_starts++;
                cnt = dly_rand ? int'($urandom_range(1, 6)) : 5;
                if (abuse && ($urandom % 3 == 0)) tile_done = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tile_done = 1'b1;
            end else if (spurious) begin
                tile_done = ($urandom % 2) == 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input bit rnd, input bit ab, input int id);
        int base;
        bit seen;
        base = n_starts;
        dly_rand = rnd;
        abuse = ab;
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            step();
            if (layer_done) seen = 1;
            else if (ab) layer_start = ($urandom % 5 == 0);
        end
        layer_start = 1'b0;
        chk("layer_done_seen", seen, 1);
        chk("tile_count", n_starts - base, TOTAL);
        $display("layer %0d: rnd_delay=%0d abuse=%0d tiles=%0d done_seen=%0d cycle=%0d",
                 id, rnd, ab, n_starts - base, seen, cyc);
        abuse = 0;
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        bit ok;
        rst_n = 1'b0;
        layer_start = 1'b0;
        abort = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Idle with stray tile_done pulses
        spurious = 1;
        repeat (10) step();
        spurious = 0;
        step();
        chk("idle_no_start", n_starts, 0);
        $display("idle: 10 cycles with stray tile_done, starts=%0d", n_starts);

        run_layer(0, 0, 1);   // fixed 5-cycle done latency
        run_layer(1, 1, 2);   // starts the cycle after FINISH, random latency + abuse

        // Abort in WAIT at tile 40
        base = n_starts;
        dly_rand = 1;
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            step();
            if ((n_starts - base == 40) && !tile_start) ok = 1;
        end
        chk("reach_tile40", ok, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("abort: issued in WAIT after %0d tiles, cycle=%0d", n_starts - base, cyc);

        // abort + layer_start together in IDLE: stays idle
        abort = 1'b1;
        layer_start = 1'b1;
        step();
        abort = 1'b0;
        layer_start = 1'b0;
        step();
        chk("abort_wins_busy", busy, 0);
        $display("abort+layer_start in idle: busy=%0d", busy);

        // Reset mid-layer
        base = n_starts;
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            step();
            if (n_starts - base >= 10) ok = 1;
        end
        chk("reach_tile10", ok, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        $display("reset mid-layer after %0d tiles, busy=%0d", n_starts - base, busy);

        run_layer(1, 1, 3);   // restarts from tile (0,0,0)

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
